// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-encoding definitions: kind/opcode values, field
// positions and the word encoder. The control decoder uses the same constants.
package instr_encoder_loader_pkg;

    // Instruction kinds; the opcode is the kind zero-extended to 6 bits
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_SW    = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_ANDI  = 4'd5;
    localparam logic [3:0] OP_ORI   = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;

    // Highest legal kind; 10-15 are rejected
    localparam logic [3:0] OP_LAST  = OP_JMP;

    // Field low-bit positions inside the 32-bit word
    localparam int OP_LSB     = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } loaderState_t;

    // Build an instruction word; fields not used by the kind are ignored
    function automatic logic [31:0] encodeInstr(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = '0;
        word[OP_LSB +: 6] = {2'b00, kind};
        if (kind == OP_RTYPE) begin
            word[RS_LSB +: 5]    = rs;
            word[RT_LSB +: 5]    = rt;
            word[RD_LSB +: 5]    = rd;
            word[SHAMT_LSB +: 5] = 5'd0;
            word[FUNCT_LSB +: 6] = funct;
        end else if (kind == OP_JMP) begin
            word[TARGET_LSB +: 26] = target;
        end else begin
            word[RS_LSB +: 5]   = rs;
            word[RT_LSB +: 5]   = rt;
            word[IMM_LSB +: 16] = imm;
        end
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Small synchronous FIFO holding encoded words between the request side and
// the memory write side. Head is visible combinationally; a push while full
// or a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]   wrPtrReg;
    logic [PTR_W:0]   rdPtrReg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic doPush;
    logic doPop;

    assign full   = (wrPtrReg[PTR_W] != rdPtrReg[PTR_W]) &&
                    (wrPtrReg[PTR_W-1:0] == rdPtrReg[PTR_W-1:0]);
    assign empty  = (wrPtrReg == rdPtrReg);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdata  = mem[rdPtrReg[PTR_W-1:0]];

    // Storage array: written on push, no reset needed
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg[PTR_W-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO and discards contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_ONE;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: encodes field-level requests into 32-bit words,
// buffers them and writes them to instruction memory at sequential addresses,
// framed by a start/done load sequence.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    input  logic              imem_stall,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;

    loaderState_t      stateReg;
    logic [ADDR_W-1:0] wrAddrReg;
    logic [ADDR_W:0]   wordCountReg;
    logic              errReg;

    logic        fifoFull;
    logic        fifoEmpty;
    logic [31:0] fifoHead;
    logic [31:0] encodedWord;
    logic        accept;
    logic        kindLegal;
    logic        fifoPush;
    logic        fifoPop;
    logic        writeActive;

    // Request side: only LOAD accepts, and never while the buffer is full
    // (even if a pop happens in the same cycle)
    assign in_ready    = (stateReg == ST_LOAD) && !fifoFull;
    assign accept      = in_valid && in_ready;
    assign kindLegal   = (in_kind <= OP_LAST);
    assign fifoPush    = accept && kindLegal;
    assign encodedWord = encodeInstr(in_kind, in_rs, in_rt, in_rd,
                                     in_funct, in_imm, in_target);

    // Write side: drains in LOAD and DRAIN whenever memory is not stalled
    assign writeActive = (stateReg == ST_LOAD) || (stateReg == ST_DRAIN);
    assign fifoPop     = writeActive && !fifoEmpty && !imem_stall;

    assign imem_we    = fifoPop;
    assign imem_addr  = wrAddrReg;
    assign imem_wdata = fifoEmpty ? 32'd0 : fifoHead;
    assign busy       = writeActive;
    assign done       = (stateReg == ST_DONE);
    assign err        = errReg;
    assign word_count = wordCountReg;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (encodedWord),
        .rdata (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Load sequencer plus write address / word counter / sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= ST_IDLE;
            wrAddrReg    <= '0;
            wordCountReg <= '0;
            errReg       <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (start) begin
                        wrAddrReg    <= base_addr;
                        wordCountReg <= '0;
                        errReg       <= 1'b0;
                        stateReg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept && !kindLegal) begin
                        errReg <= 1'b1;
                    end
                    if (accept && in_last) begin
                        stateReg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifoEmpty) begin
                        stateReg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    stateReg <= ST_IDLE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase

            // Each memory write advances the address (wrapping) and the count
            if (fifoPop) begin
                wrAddrReg    <= wrAddrReg + ADDR_ONE;
                wordCountReg <= wordCountReg + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus pushes expected
// {address, word} pairs, a monitor pops and compares on every memory write.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;

    typedef struct {
        int kind;
        int rs;
        int rt;
        int rd;
        int funct;
        int imm;
        int target;
        bit last;
    } req_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int tests = 0;
    int fails = 0;

    logic [39:0]       sb [$];
    logic [ADDR_W-1:0] modelAddr;
    int                modelCount;
    bit                modelErr;
    bit                stallForce;
    bit                stallRandom;

    instr_encoder_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .imem_stall (imem_stall),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference word built from the field layout with plain arithmetic
    function automatic logic [31:0] refWord(input req_t r);
        longint w;
        w = longint'(r.kind) * 64'd67108864;
        if (r.kind == 0)
            w += longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048 + longint'(r.funct);
        else if (r.kind == 9)
            w += longint'(r.target);
        else
            w += longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.imm);
        return w[31:0];
    endfunction

    function automatic req_t mkReq(input int kind, input bit last);
        req_t r;
        r.kind   = kind;
        r.rs     = int'($urandom_range(0, 31));
        r.rt     = int'($urandom_range(0, 31));
        r.rd     = int'($urandom_range(0, 31));
        r.funct  = int'($urandom_range(0, 63));
        r.imm    = int'($urandom_range(0, 65535));
        r.target = int'($urandom & 32'h03FF_FFFF);
        r.last   = last;
        return r;
    endfunction

    task automatic driveReq(input req_t r);
        logic [31:0] v;
        v = r.kind;   in_kind   = v[3:0];
        v = r.rs;     in_rs     = v[4:0];
        v = r.rt;     in_rt     = v[4:0];
        v = r.rd;     in_rd     = v[4:0];
        v = r.funct;  in_funct  = v[5:0];
        v = r.imm;    in_imm    = v[15:0];
        v = r.target; in_target = v[25:0];
        in_last = r.last;
    endtask

    // Reference model: legal kinds produce a word at the next address
    task automatic modelAccept(input req_t r, input bit useExp, input logic [31:0] expWord);
        if (r.kind <= 9) begin
            sb.push_back({modelAddr, (useExp ? expWord : refWord(r))});
            modelAddr  = modelAddr + 8'd1;
            modelCount++;
        end else begin
            modelErr = 1'b1;
        end
    endtask

    // Called at posedge+1; offers a request until accepted (bounded)
    task automatic sendReq(input req_t r, input bit useExp = 1'b0, input logic [31:0] expWord = 32'd0);
        bit ok;
        ok = 1'b0;
        driveReq(r);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) modelAccept(r, useExp, expWord);
        else check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic doStart(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start      = 1'b0;
        modelAddr  = base;
        modelCount = 0;
        modelErr   = 1'b0;
        check("start_err_clear", 64'(err), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_wcount", 64'(word_count), 64'd0);
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_wcount"}, 64'(word_count), 64'(modelCount));
        check({name, "_err"}, 64'(err), 64'(modelErr));
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Memory-stall driver: forced or random
    initial begin
        imem_stall = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            imem_stall = stallForce | (stallRandom && ($urandom_range(0, 2) == 0));
        end
    end

    // Monitor: every memory write must match the oldest expected entry
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && imem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(imem_addr), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] write addr=0x%02h data=0x%08h", imem_addr, imem_wdata);
                    check("imem_addr", 64'(imem_addr), 64'(e[39:32]));
                    check("imem_wdata", 64'(imem_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        req_t r;
        req_t reqs [6];
        int   k;
        int   len;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
        stallForce = 1'b0; stallRandom = 1'b0;
        modelAddr = '0; modelCount = 0; modelErr = 1'b0;

        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_wcount", 64'(word_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi rs=1 rt=2 imm=5
        doStart(8'h10);
        r = mkReq(3, 1'b1); r.rs = 1; r.rt = 2; r.imm = 5;
        sendReq(r, 1'b1, 32'h0C22_0005);
        waitDone("addi");

        // R-type then jmp
        doStart(8'h30);
        r = mkReq(0, 1'b0); r.rs = 1; r.rt = 2; r.rd = 3; r.funct = 32'h20;
        sendReq(r, 1'b1, 32'h0022_1820);
        r = mkReq(9, 1'b1); r.target = 32'h40;
        sendReq(r, 1'b1, 32'h2400_0040);
        waitDone("rj");

        // beq then illegal kind with last
        doStart(8'h50);
        r = mkReq(7, 1'b0); r.rs = 4; r.rt = 5; r.imm = 32'hFFFE;
        sendReq(r, 1'b1, 32'h1C85_FFFE);
        r = mkReq(12, 1'b1);
        sendReq(r);
        waitDone("beq_illegal");

        // Empty load: first request illegal with last
        doStart(8'h60);
        r = mkReq(13, 1'b1);
        sendReq(r);
        waitDone("empty");

        // Stall held: buffer fills after 4, then drains in order
        stallForce = 1'b1;
        @(posedge clk);
        #1;
        doStart(8'h20);
        for (int i = 0; i < 6; i++) reqs[i] = mkReq(int'($urandom_range(0, 9)), i == 5);
        k = 0;
        driveReq(reqs[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                modelAccept(reqs[k], 1'b0, 32'd0);
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 6) driveReq(reqs[k]);
            else in_valid = 1'b0;
        end
        check("stall_accepted", 64'(k), 64'd4);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_no_writes", 64'(sb.size()), 64'd4);
        stallForce = 1'b0;
        for (int c = 0; c < 200 && k < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                modelAccept(reqs[k], 1'b0, 32'd0);
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 6) driveReq(reqs[k]);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("stall_all_accepted", 64'(k), 64'd6);
        waitDone("stall");

        // Address wrap
        doStart(8'hFE);
        for (int i = 0; i < 3; i++) sendReq(mkReq(int'($urandom_range(0, 9)), i == 2));
        waitDone("wrap");

        // Randomized loads with random stalls, gaps and illegal kinds
        stallRandom = 1'b1;
        for (int l = 0; l < 8; l++) begin
            doStart(8'($urandom_range(0, 255)));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                sendReq(mkReq(int'($urandom_range(0, 11)), i == len - 1));
            end
            waitDone("rand");
        end
        stallRandom = 1'b0;

        // Reset while draining with 2 words buffered
        stallForce = 1'b1;
        @(posedge clk);
        #1;
        doStart(8'h40);
        sendReq(mkReq(3, 1'b0));
        sendReq(mkReq(5, 1'b1));
        #2;
        check("drain_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_we", 64'(imem_we), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'd0);
        check("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        check("mid_rst_wcount", 64'(word_count), 64'd0);
        stallForce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_wcount", 64'(word_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes field-level instruction requests into 32-bit instruction words using the opcode map consumed by the core's control decoder, and writes them into instruction memory. It sits between the testbench/boot host and the instruction memory write port. Requests arrive over a valid/ready stream, are buffered in a small FIFO and drained to memory at sequential word addresses. A start/done load sequence frames each load.

Parameters:
ADDR_W, 8, instruction memory word-address width
FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load sequence
base_addr  in  ADDR_W  first word address, sampled on start
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_kind  in  4  0 R, 1 sw, 2 lw, 3 addi, 4 slti, 5 andi, 6 ori, 7 beq, 8 bne, 9 jmp; 10-15 illegal
in_rs  in  5  source register
in_rt  in  5  target register
in_rd  in  5  destination register, R-type only
in_funct  in  6  function field, R-type only
in_imm  in  16  immediate/offset, I-type only
in_target  in  26  jump target, jmp only
in_last  in  1  marks final request of the load
imem_stall  in  1  memory cannot accept a write this cycle
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded instruction
busy  out  1  high in LOAD or DRAIN
done  out  1  one-cycle pulse at end of load
err  out  1  sticky illegal-kind flag
word_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (async, rst_n low): state IDLE; FIFO empty; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, word_count = 0.
- Word format: op[31:26] = in_kind zero-extended to 6 bits.
- R (kind 0): rs[25:21], rt[20:16], rd[15:11], shamt[10:6] = 0, funct[5:0].
- Kinds 1-8: rs[25:21], rt[20:16], imm[15:0].
- jmp (kind 9): target[25:0].
- Unused input fields are ignored.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: on start, load write pointer with base_addr, clear word_count and err, go to LOAD. start outside IDLE is ignored.
- LOAD: in_ready = !fifo_full. An accepted legal request is encoded and pushed. An accepted illegal kind (10-15) is consumed but not pushed, and sets err. An accepted request with in_last (legal or not) goes to DRAIN.
- DRAIN: in_ready = 0. When the FIFO is empty, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Write side, in LOAD and DRAIN: imem_we = !fifo_empty & !imem_stall, with imem_wdata = FIFO head and imem_addr = write pointer. On each write, pop the FIFO, increment the pointer (wraps modulo 2^ADDR_W, no error) and increment word_count.
- Latency: a request accepted at edge N appears on imem_we no earlier than the cycle after edge N. There is no combinational bypass from input to memory.
- A full FIFO with a simultaneous pop still deasserts in_ready that cycle (no same-cycle push-on-pop).
- imem_stall held high: the FIFO fills, in_ready drops, nothing is lost, and write order is preserved.
- An empty load (first accepted request is illegal with in_last) gives DRAIN, then DONE with word_count 0 and err 1.
- Reset mid-load: everything returns to reset values immediately; buffered words are discarded.
- busy = (state == LOAD or DRAIN). err holds until the next start.

Decomposition:
- Shared package: instruction kind/opcode constants (OP_RTYPE=0 … OP_JMP=9), field bit-position constants, and an encode function. The control decoder uses the same constants.
- Sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH) with push/pop/full/empty.

Test Plan:
- start with base_addr=0x10; addi rs=1 rt=2 imm=0x0005, last=1 → imem_we once, addr 0x10, wdata 0x0C220005; done pulse; word_count=1.
- R-type rs=1 rt=2 rd=3 funct=0x20, then jmp target=0x40 last → 0x00221820 @base, 0x24000040 @base+1.
- beq rs=4 rt=5 imm=0xFFFE → 0x1C85FFFE. Then kind=12 with last → no write, err=1, word_count=1; err clears on next start.
- imem_stall high for 10 cycles while 6 requests are offered → in_ready low after 4 accepted. Release stall → all 6 written in order at consecutive addresses.
- base_addr=0xFE, 3 legal requests → addresses 0xFE, 0xFF, 0x00.
- rst_n pulled low in DRAIN with 2 words buffered → outputs zero immediately, no further writes, state IDLE.
